// File: rtl/fpc_pkg.sv
// Shared definitions for FloPoCo-format datapath blocks: exception codes,
// operand width helper and the max-pool sequencer state encoding.
package fpc_pkg;

  localparam logic [1:0] FPC_EXC_ZERO   = 2'b00;
  localparam logic [1:0] FPC_EXC_NORMAL = 2'b01;
  localparam logic [1:0] FPC_EXC_INF    = 2'b10;
  localparam logic [1:0] FPC_EXC_NAN    = 2'b11;

  function automatic int fpc_width(input int we, input int wf);
    return we + wf + 3;
  endfunction

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    EMIT
  } maxpool_state_t;

endpackage

// File: rtl/fcmp_maxpool_seq_if.sv
// Operand-in / result-out handshake bundle of the max-pool sequencer.
interface fcmp_maxpool_seq_if
  import fpc_pkg::*;
#(
  parameter int WE    = 7,
  parameter int WF    = 7,
  parameter int IDX_W = 2
);

  localparam int DATA_W = fpc_width(WE, WF);

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [IDX_W-1:0]  out_idx;
  logic              out_nan;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_idx, out_nan
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_idx, out_nan
  );

endinterface

// File: rtl/fcmp_maxpool_seq_fcmplt.sv
// Combinational FloPoCo less-than comparator: XltY = X < Y, unordered when
// either operand is NaN. Signed zeros compare equal.
module fcmplt
  import fpc_pkg::*;
#(
  parameter int WE = 7,
  parameter int WF = 7,
  parameter int ID = 0
) (
  input  logic [WE+WF+2:0] X,
  input  logic [WE+WF+2:0] Y,
  output logic             XltY,
  output logic             unordered
);

  localparam int MAG_W = WE + WF + 2;

  if (WE < 1 || WF < 1 || ID < 0) begin : g_bad_param
    $error("fcmplt: illegal WE/WF/ID");
  end

  // Magnitude key ordered zero < normal < inf; payload ignored for zero/inf.
  function automatic logic [MAG_W-1:0] fpc_mag(input logic [WE+WF+2:0] v);
    case (v[WE+WF+2 -: 2])
      FPC_EXC_NORMAL: return {FPC_EXC_NORMAL, v[WE+WF-1:0]};
      FPC_EXC_INF:    return {FPC_EXC_INF, {(WE+WF){1'b0}}};
      default:        return '0;
    endcase
  endfunction

  function automatic logic fpc_sign(input logic [WE+WF+2:0] v);
    return v[WE+WF] & (v[WE+WF+2 -: 2] != FPC_EXC_ZERO);
  endfunction

  logic [MAG_W-1:0] mag_x, mag_y;
  logic             sign_x, sign_y;
  logic             lt;

  assign mag_x  = fpc_mag(X);
  assign mag_y  = fpc_mag(Y);
  assign sign_x = fpc_sign(X);
  assign sign_y = fpc_sign(Y);

  always_comb begin
    unordered = (X[WE+WF+2 -: 2] == FPC_EXC_NAN) | (Y[WE+WF+2 -: 2] == FPC_EXC_NAN);
    if (sign_x != sign_y) lt = sign_x;
    else if (sign_x)      lt = mag_x > mag_y;
    else                  lt = mag_x < mag_y;
    XltY = lt & ~unordered;
  end

endmodule

// File: rtl/fcmp_maxpool_seq.sv
// Streaming max-pool sequencer: one FloPoCo element per cycle through a shared
// fcmplt, emitting max, argmax and NaN flag once per WINDOW elements.
module fcmp_maxpool_seq
  import fpc_pkg::*;
#(
  parameter int WE     = 7,
  parameter int WF     = 7,
  parameter int WINDOW = 4,
  parameter int IDX_W  = (WINDOW > 1) ? $clog2(WINDOW) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  fcmp_maxpool_seq_if.slave   bus
);

  localparam int                DATA_W    = fpc_width(WE, WF);
  localparam logic [IDX_W-1:0]  LAST      = IDX_W'(WINDOW - 1);
  localparam logic [DATA_W-1:0] CANON_NAN = {FPC_EXC_NAN, {(DATA_W-2){1'b0}}};

  if (WINDOW < 1 || WINDOW > 256) begin : g_bad_window
    $error("fcmp_maxpool_seq: WINDOW must be 1..256");
  end

  function automatic logic [DATA_W-1:0] nan_canon(input logic nan,
                                                  input logic [DATA_W-1:0] v);
    return nan ? CANON_NAN : v;
  endfunction

  maxpool_state_t    state, state_next;
  logic [IDX_W-1:0]  count;
  logic [IDX_W-1:0]  idx_r, idx_next;
  logic [DATA_W-1:0] max_r, max_next;
  logic              nan_r, nan_next;
  logic              accept, last, first;
  logic              xlty, unordered;
  logic              out_valid_next;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic [IDX_W-1:0]  out_idx;
  logic              out_nan;

  fcmplt #(.WE(WE), .WF(WF), .ID(0)) u_fcmplt (
    .X         (max_r),
    .Y         (bus.in_data),
    .XltY      (xlty),
    .unordered (unordered)
  );

  assign bus.in_ready  = (state != EMIT) | bus.out_ready;
  assign accept        = bus.in_valid & bus.in_ready;
  assign first         = (count == '0);
  assign last          = (count == LAST);
  assign bus.out_valid = out_valid;
  assign bus.out_data  = out_data;
  assign bus.out_idx   = out_idx;
  assign bus.out_nan   = out_nan;

  always_comb begin
    state_next = state;
    if (accept)                              state_next = last ? EMIT : ACCUM;
    else if (state == EMIT && bus.out_ready) state_next = IDLE;
    out_valid_next = (accept & last) | (out_valid & ~bus.out_ready);
  end

  // Running reduction; ties and -0/+0 keep the earlier element.
  always_comb begin
    max_next = max_r;
    idx_next = idx_r;
    nan_next = nan_r;
    if (first) begin
      max_next = bus.in_data;
      idx_next = '0;
      nan_next = (bus.in_data[DATA_W-1 -: 2] == FPC_EXC_NAN);
    end else if (unordered) begin
      nan_next = 1'b1;
    end else if (xlty) begin
      max_next = bus.in_data;
      idx_next = count;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      count     <= '0;
      max_r     <= '0;
      idx_r     <= '0;
      nan_r     <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_idx   <= '0;
      out_nan   <= 1'b0;
    end else begin
      state     <= state_next;
      out_valid <= out_valid_next;
      if (accept) begin
        max_r <= max_next;
        idx_r <= idx_next;
        nan_r <= nan_next;
        count <= last ? '0 : count + 1'b1;
        if (last) begin
          out_data <= nan_canon(nan_next, max_next);
          out_idx  <= idx_next;
          out_nan  <= nan_next;
        end
      end
    end
  end

endmodule

// File: tb/tb_fcmp_maxpool_seq.sv
// Directed bench for fcmp_maxpool_seq (WINDOW=4) with hand-computed results.
module tb_fcmp_maxpool_seq;
  import fpc_pkg::*;

  localparam int WE     = 7;
  localparam int WF     = 7;
  localparam int WINDOW = 4;
  localparam int IDX_W  = 2;
  localparam int DATA_W = WE + WF + 3;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  fcmp_maxpool_seq_if #(.WE(WE), .WF(WF), .IDX_W(IDX_W)) bus ();

  fcmp_maxpool_seq #(.WE(WE), .WF(WF), .WINDOW(WINDOW), .IDX_W(IDX_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one element (in_valid left high) and checks it is accepted.
  task automatic send_elem(input string tag, input logic [DATA_W-1:0] d);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    check({tag, " in_ready"}, 32'(bus.in_ready), 32'd1);
    tick();
  endtask

  task automatic send_window(input string tag,
                             input logic [DATA_W-1:0] e0, input logic [DATA_W-1:0] e1,
                             input logic [DATA_W-1:0] e2, input logic [DATA_W-1:0] e3);
    logic [DATA_W-1:0] e [4];
    e = '{e0, e1, e2, e3};
    for (int i = 0; i < WINDOW; i++) begin
      send_elem($sformatf("%s e%0d", tag, i), e[i]);
      if (i < WINDOW - 1)
        check($sformatf("%s early valid e%0d", tag, i), 32'(bus.out_valid), 32'd0);
    end
  endtask

  task automatic expect_result(input string tag, input logic [DATA_W-1:0] d,
                               input logic [IDX_W-1:0] idx, input logic nan);
    check({tag, " out_valid"}, 32'(bus.out_valid), 32'd1);
    check({tag, " out_data"},  32'(bus.out_data),  32'(d));
    check({tag, " out_idx"},   32'(bus.out_idx),   32'(idx));
    check({tag, " out_nan"},   32'(bus.out_nan),   32'(nan));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst out_valid", 32'(bus.out_valid), 32'd0);
    check("rst out_data",  32'(bus.out_data),  32'd0);
    check("rst out_idx",   32'(bus.out_idx),   32'd0);
    check("rst out_nan",   32'(bus.out_nan),   32'd0);
    check("rst in_ready",  32'(bus.in_ready),  32'd1);
    rst_n = 1'b1;
    tick();

    send_window("t1", 17'h09F80, 17'h0A000, 17'h09F00, 17'h0DF80);
    expect_result("t1", 17'h0A000, 2'd1, 1'b0);
    bus.in_valid = 1'b0;
    tick();
    check("t1 drop valid", 32'(bus.out_valid), 32'd0);

    send_window("t2", 17'h0DF80, 17'h00000, 17'h0DF80, 17'h10000);
    expect_result("t2", 17'h10000, 2'd3, 1'b0);
    bus.in_valid = 1'b0;
    tick();

    // NaN window followed back-to-back by a tie window
    send_window("t3", 17'h09F80, 17'h18000, 17'h0A000, 17'h09F00);
    expect_result("t3", 17'h18000, 2'd2, 1'b1);
    send_window("t4", 17'h0A000, 17'h0A000, 17'h0A000, 17'h0A000);
    expect_result("t4", 17'h0A000, 2'd0, 1'b0);
    bus.in_valid = 1'b0;
    tick();

    send_window("t4z", 17'h00000, 17'h04000, 17'h0DF80, 17'h0DF80);
    expect_result("t4z", 17'h00000, 2'd0, 1'b0);
    bus.in_valid = 1'b0;
    tick();
    send_window("t4n", 17'h04000, 17'h00000, 17'h0DF80, 17'h04000);
    expect_result("t4n", 17'h04000, 2'd0, 1'b0);
    bus.in_valid = 1'b0;
    tick();

    // Backpressure with a pending element
    bus.out_ready = 1'b0;
    send_window("t5", 17'h09F00, 17'h09F80, 17'h0A000, 17'h0DF80);
    expect_result("t5", 17'h0A000, 2'd2, 1'b0);
    bus.in_valid = 1'b1;
    bus.in_data  = 17'h0A010;
    for (int i = 0; i < 5; i++) begin
      check($sformatf("t5 stall%0d in_ready", i), 32'(bus.in_ready), 32'd0);
      expect_result($sformatf("t5 stall%0d", i), 17'h0A000, 2'd2, 1'b0);
      tick();
    end
    bus.out_ready = 1'b1;
    #1;
    check("t5 release in_ready", 32'(bus.in_ready), 32'd1);
    tick();
    check("t5 taken", 32'(bus.out_valid), 32'd0);
    send_elem("t5 e1", 17'h09F80);
    send_elem("t5 e2", 17'h0A000);
    send_elem("t5 e3", 17'h09F00);
    expect_result("t5 next", 17'h0A010, 2'd0, 1'b0);
    bus.in_valid = 1'b0;
    tick();

    // Reset while a result is held, then reset mid-window
    bus.out_ready = 1'b0;
    send_window("t6a", 17'h09F80, 17'h0A000, 17'h09F00, 17'h0DF80);
    expect_result("t6a", 17'h0A000, 2'd1, 1'b0);
    bus.in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("t6 rst out_valid", 32'(bus.out_valid), 32'd0);
    check("t6 rst out_data",  32'(bus.out_data),  32'd0);
    check("t6 rst out_idx",   32'(bus.out_idx),   32'd0);
    tick();
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    tick();
    send_elem("t6 p0", 17'h10000);
    send_elem("t6 p1", 17'h09F80);
    bus.in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("t6 mid rst out_valid", 32'(bus.out_valid), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    send_window("t6b", 17'h09F00, 17'h0DF80, 17'h0A000, 17'h09F80);
    expect_result("t6b", 17'h0A000, 2'd2, 1'b0);
    bus.in_valid = 1'b0;
    tick();
    check("t6b drained", 32'(bus.out_valid), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
